uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Asynchronous serial (UART) receiver: 8N1-style frames with parameterised bit time, data width and stop-bit count.
- Oversamples a single rx line with the system clock and samples each bit at its centre.
- Presents the received word with a one-cycle valid strobe.
- Sits between an external serial pin and on-chip consumers (e.g. FIFO or command parser).

Parameters:
- p_BITSLOT_HALF_PERIOD, 8, clock cycles in half a bit period (H); bit period = 2*H cycles; must be >=1.
- p_DATA_BITS, 8, data bits per frame (D), LSB first; legal range 1..16.
- p_STOP_BITS, 1, stop bits per frame (S); must be >=1.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_rx  input  1  serial line; idle high.
- o_data  output  p_DATA_BITS  last correctly framed word; holds until next valid frame.
- o_data_ready  output  1  one-cycle strobe: o_data updated this cycle.
- o_frame_err  output  1  one-cycle strobe: a stop bit was sampled low.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE, counters=0, shift register=0.
  - o_data=0, o_data_ready=0, o_frame_err=0.
  - Reset mid-frame aborts the frame; no strobe is produced.
- Timing:
  - "rx" means the internal rx sample; see Optional Feature for the synchroniser.
  - Cycle 0 is the first rising edge at which rx=0 is seen in IDLE.
- States:
  - IDLE: wait for rx=0, then go to START with counter loaded.
  - START: at cycle H (mid start bit), sample rx. If rx=1 it was a glitch: return to IDLE with no strobe. If rx=0, go to DATA.
  - DATA: data bit k (k=0..D-1) is sampled at cycle H+2H*(k+1) and shifted in LSB first (bit 0 received first). After bit D-1, go to STOP.
  - STOP: stop bit j (j=0..S-1) is sampled at cycle H+2H*(D+1+j).
    - Any stop sample of 0: pulse o_frame_err for one cycle, leave o_data unchanged, go to BREAK.
    - Last stop sample of 1: load o_data from the shift register and pulse o_data_ready on that same edge, then go to IDLE.
  - BREAK: wait until rx=1, then go to IDLE. A held-low line never re-triggers a frame.
- Strobes:
  - o_data_ready and o_frame_err are never high together.
  - Each is high for exactly one cycle per frame.
- Back-to-back frames: after the last stop-bit sample the receiver is in IDLE. A start edge arriving H cycles later (nominal next frame) is detected normally.
- Counters:
  - Bit-time counter width is clog2(2*H).
  - Bit index width is clog2(max(D,S)+1).
  - No wrap-around hazards; counters reload on every sample.
- Errors: no parity checking; no line-noise voting (single sample per bit).

Optional Feature:
- Macro UART_RX_SYNC_EN.
- When defined: i_rx passes through a two-flop synchroniser, reset to 1, before the state machine. All sample cycles above shift 2 cycles later relative to the i_rx pin.
- When undefined: i_rx is used directly as the rx sample, with no added latency. The input must then be synchronous to i_clk.

Test Plan:
- H=1, D=1, S=3: idle high 5 cycles, rx low 2 cycles, then high. Required: o_data=1, o_data_ready pulses once, exactly at cycle 1+2*(1+1+2)=9 after the first low sample; o_frame_err stays 0.
- H=4, D=8, S=1: send 0xA5 LSB first (bits 1,0,1,0,0,1,0,1), stop=1. Required: o_data=0xA5 with a one-cycle o_data_ready at cycle 4+8*9=76; o_data holds 0xA5 afterwards.
- H=4, D=8, S=1: send 0x3C with stop bit driven 0 for a full bit, then line high. Required: o_frame_err pulses once; o_data keeps its prior value; no o_data_ready. A following valid 0x5A frame is received correctly.
- H=4: 2-cycle low glitch on idle line. Required: START check at cycle 4 sees 1, return to IDLE, no strobe of either kind.
- Hold rx low for 20 bit times after a framing error. Required: only one o_frame_err; no further activity until rx returns high. A subsequent valid frame is accepted.
- Assert i_rst mid-DATA (after 3 bits). Required: outputs 0 immediately (asynchronously), no strobe. The next full frame 0x81 is received as 0x81.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: centre-sampled start/data/stop bits, one-cycle ready/error strobes.
// Optional two-flop input synchroniser enabled by defining UART_RX_SYNC_EN.
`timescale 1ns/1ps
module uart_rx #(
    parameter int unsigned p_BITSLOT_HALF_PERIOD = 8,
    parameter int unsigned p_DATA_BITS           = 8,
    parameter int unsigned p_STOP_BITS           = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rx,
    output logic [p_DATA_BITS-1:0] o_data,
    output logic                   o_data_ready,
    output logic                   o_frame_err
);

    localparam int unsigned H      = p_BITSLOT_HALF_PERIOD;
    localparam int unsigned D      = p_DATA_BITS;
    localparam int unsigned S      = p_STOP_BITS;
    localparam int unsigned CntW   = (2 * H > 1) ? $clog2(2 * H) : 1;
    localparam int unsigned MaxDS  = (D > S) ? D : S;
    localparam int unsigned IdxW   = $clog2(MaxDS + 1);

    localparam logic [CntW-1:0] HalfLoad = CntW'(H - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(2 * H - 1);
    localparam logic [IdxW-1:0] LastData = IdxW'(D - 1);
    localparam logic [IdxW-1:0] LastStop = IdxW'(S - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [D-1:0]    shift_q, shift_d;
    logic [D-1:0]    data_q, data_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;
    logic            rx;
    logic            sample;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_rx};
        end
    end

    assign rx = sync_q[1];
`else
    assign rx = i_rx;
`endif

    // Counter reaches zero exactly at the centre of the current bit.
    assign sample = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        ready_d = 1'b0;
        err_d   = 1'b0;

        if (state_q != StIdle && state_q != StBreak && !sample) begin
            cnt_d = cnt_q - 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (!rx) begin
                    state_d = StStart;
                    cnt_d   = HalfLoad;
                    idx_d   = '0;
                end
            end
            StStart: begin
                if (sample) begin
                    if (rx) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        cnt_d   = FullLoad;
                    end
                end
            end
            StData: begin
                if (sample) begin
                    shift_d        = shift_q >> 1;
                    shift_d[D-1]   = rx;
                    cnt_d          = FullLoad;
                    if (idx_q == LastData) begin
                        state_d = StStop;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (sample) begin
                    cnt_d = FullLoad;
                    if (!rx) begin
                        err_d   = 1'b1;
                        state_d = StBreak;
                        idx_d   = '0;
                    end else if (idx_q == LastStop) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StBreak: begin
                // A held-low line must not be mistaken for a new start bit.
                if (rx) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign o_data       = data_q;
    assign o_data_ready = ready_q;
    assign o_frame_err  = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: two configurations, scoreboard of expected strobes.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned HA = 1, DA = 1, SA = 3;
    localparam int unsigned HB = 4, DB = 8, SB = 1;
`ifdef UART_RX_SYNC_EN
    localparam int SyncLat = 2;
`else
    localparam int SyncLat = 0;
`endif
    localparam int LatA = HA + 2 * HA * (DA + 1 + SA - 1);
    localparam int LatB = HB + 2 * HB * (DB + 1 + SB - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    logic [DA-1:0] data_a;
    logic [DB-1:0] data_b;
    logic ready_a, err_a, ready_b, err_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit          err;
        logic [15:0] data;
        int          at;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    logic [7:0] last_b = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(
        .p_BITSLOT_HALF_PERIOD(HA),
        .p_DATA_BITS(DA),
        .p_STOP_BITS(SA)
    ) u_dut_a (
        .i_clk(clk),
        .i_rst(rst),
        .i_rx(rx_a),
        .o_data(data_a),
        .o_data_ready(ready_a),
        .o_frame_err(err_a)
    );

    uart_rx #(
        .p_BITSLOT_HALF_PERIOD(HB),
        .p_DATA_BITS(DB),
        .p_STOP_BITS(SB)
    ) u_dut_b (
        .i_clk(clk),
        .i_rst(rst),
        .i_rx(rx_b),
        .o_data(data_b),
        .o_data_ready(ready_b),
        .o_frame_err(err_b)
    );

    // Scoreboard monitors: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (ready_a === 1'b1 && err_a === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL strobe_excl_a ready=1 err=1 required not both");
        end else if (ready_a === 1'b1 || err_a === 1'b1) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL unexpected_a ready=%0b err=%0b cyc=%0d required no strobe",
                         ready_a, err_a, cyc);
            end else begin
                ea = q_a.pop_front();
                if (err_a !== ea.err || data_a !== ea.data[DA-1:0] || cyc != ea.at) begin
                    errors++;
                    $display("FAIL strobe_a err=%0b data=%0h cyc=%0d required err=%0b data=%0h cyc=%0d",
                             err_a, data_a, cyc, ea.err, ea.data[DA-1:0], ea.at);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ready_b === 1'b1 && err_b === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL strobe_excl_b ready=1 err=1 required not both");
        end else if (ready_b === 1'b1 || err_b === 1'b1) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL unexpected_b ready=%0b err=%0b cyc=%0d required no strobe",
                         ready_b, err_b, cyc);
            end else begin
                eb = q_b.pop_front();
                if (err_b !== eb.err || data_b !== eb.data[DB-1:0] || cyc != eb.at) begin
                    errors++;
                    $display("FAIL strobe_b err=%0b data=%0h cyc=%0d required err=%0b data=%0h cyc=%0d",
                             err_b, data_b, cyc, eb.err, eb.data[DB-1:0], eb.at);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic bit_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_b(input bit err, input logic [7:0] d, input int at);
        exp_t e;
        e.err  = err;
        e.data = {8'h00, d};
        e.at   = at;
        q_b.push_back(e);
    endtask

    // Drive one frame on rx_b, starting at the next rising edge.
    task automatic send_b(input logic [7:0] d, input bit stop_ok, input int hold_low_bits);
        @(posedge clk);
        #1;
        if (stop_ok) begin
            push_b(1'b0, d, cyc + 1 + LatB + SyncLat);
            last_b = d;
        end else begin
            push_b(1'b1, last_b, cyc + 1 + LatB + SyncLat);
        end
        rx_b = 1'b0;
        bit_wait(2 * HB);
        for (int k = 0; k < 8; k++) begin
            rx_b = d[k];
            bit_wait(2 * HB);
        end
        rx_b = stop_ok;
        bit_wait(2 * HB);
        if (!stop_ok && hold_low_bits > 0) bit_wait(2 * HB * hold_low_bits);
        rx_b = 1'b1;
        bit_wait(2 * HB);
    endtask

    task automatic drain_a(input string name);
        int n = 0;
        while (q_a.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (q_a.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required 0", name, q_a.size());
            q_a.delete();
        end
    endtask

    task automatic drain_b(input string name);
        int n = 0;
        while (q_b.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (q_b.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required 0", name, q_b.size());
            q_b.delete();
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (data_a !== '0 || ready_a !== 1'b0 || err_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a data=%0h ready=%0b err=%0b required 0 0 0",
                     data_a, ready_a, err_a);
        end
        checks++;
        if (data_b !== '0 || ready_b !== 1'b0 || err_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b data=%0h ready=%0b err=%0b required 0 0 0",
                     data_b, ready_b, err_b);
        end
        bit_wait(3);
        rst = 1'b0;
        bit_wait(3);
    endtask

    task automatic test_min_frame();
        exp_t e;
        rx_a = 1'b1;
        bit_wait(5);
        e.err  = 1'b0;
        e.data = 16'h0001;
        e.at   = cyc + 1 + LatA + SyncLat;
        q_a.push_back(e);
        rx_a = 1'b0;
        bit_wait(2);
        rx_a = 1'b1;
        drain_a("min_frame");
        bit_wait(10);
        checks++;
        if (data_a !== 1'b1) begin
            errors++;
            $display("FAIL min_frame_hold data=%0h required 1", data_a);
        end
    endtask

    task automatic test_a5();
        send_b(8'hA5, 1'b1, 0);
        drain_b("a5");
        bit_wait(20);
        checks++;
        if (data_b !== 8'hA5) begin
            errors++;
            $display("FAIL a5_hold data=%0h required a5", data_b);
        end
    endtask

    task automatic test_frame_err();
        send_b(8'h3C, 1'b0, 0);
        drain_b("frame_err");
        checks++;
        if (data_b !== 8'hA5) begin
            errors++;
            $display("FAIL frame_err_hold data=%0h required a5", data_b);
        end
        bit_wait(4);
        send_b(8'h5A, 1'b1, 0);
        drain_b("after_err");
    endtask

    task automatic test_glitch();
        @(posedge clk);
        #1;
        rx_b = 1'b0;
        bit_wait(2);
        rx_b = 1'b1;
        bit_wait(100);
        checks++;
        if (data_b !== last_b || q_b.size() != 0) begin
            errors++;
            $display("FAIL glitch data=%0h pending=%0d required data=%0h pending=0",
                     data_b, q_b.size(), last_b);
        end
    endtask

    task automatic test_break();
        send_b(8'h3C, 1'b0, 20);
        drain_b("break");
        bit_wait(4);
        send_b(8'h99, 1'b1, 0);
        drain_b("after_break");
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'h81;
        @(posedge clk);
        #1;
        rx_b = 1'b0;
        bit_wait(2 * HB);
        for (int k = 0; k < 3; k++) begin
            rx_b = d[k];
            bit_wait(2 * HB);
        end
        bit_wait(2);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (data_b !== '0 || ready_b !== 1'b0 || err_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid data=%0h ready=%0b err=%0b required 0 0 0",
                     data_b, ready_b, err_b);
        end
        rx_b = 1'b1;
        last_b = 8'h00;
        bit_wait(5);
        rst = 1'b0;
        bit_wait(5);
        send_b(8'h81, 1'b1, 0);
        drain_b("after_reset");
        checks++;
        if (data_b !== 8'h81) begin
            errors++;
            $display("FAIL reset_recover data=%0h required 81", data_b);
        end
    endtask

    initial begin
        test_reset();
        test_min_frame();
        test_a5();
        test_frame_err();
        test_glitch();
        test_break();
        test_reset_mid();
        bit_wait(50);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
